// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: default widths, the
// sequential PC step and the layout of one queued prediction.
package branch_resolve_unit_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int IDX_BITS_DEF = 8;
    localparam int DEPTH_DEF    = 4;
    localparam int PC_STEP      = 4;

    // Field order matches the packing used for the prediction queue storage.
    typedef struct packed {
        logic [XLEN_DEF-1:0]     pc;
        logic                    taken;
        logic [XLEN_DEF-1:0]     target;
        logic [IDX_BITS_DEF-1:0] index;
    } pred_entry_t;

endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// Circular prediction FIFO with a flush that empties it in one edge.
// The caller only pushes when not full and only pops when not empty.
module pred_queue
    import branch_resolve_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush dominates a simultaneous push or pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Queues fetch-time branch predictions, checks each against its execute
// outcome, and produces the redirect pulse plus the predictor training strobe.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int IDX_BITS = IDX_BITS_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_valid_i,
    output logic                push_ready_o,
    input  logic [XLEN-1:0]     push_pc_i,
    input  logic                push_taken_i,
    input  logic [XLEN-1:0]     push_target_i,
    input  logic [IDX_BITS-1:0] push_index_i,
    input  logic                res_valid_i,
    input  logic                res_taken_i,
    input  logic [XLEN-1:0]     res_target_i,
    output logic                mispredict_o,
    output logic [XLEN-1:0]     redirect_pc_o,
    output logic                upd_valid_o,
    output logic                upd_taken_o,
    output logic [IDX_BITS-1:0] upd_index_o,
    output logic [CW-1:0]       count_o,
    output logic [31:0]         miss_cnt_o
);

    localparam int EW = 2 * XLEN + 1 + IDX_BITS;

    logic [EW-1:0]       push_entry;
    logic [EW-1:0]       head_entry;
    logic [XLEN-1:0]     head_pc;
    logic                head_taken;
    logic [XLEN-1:0]     head_target;
    logic [IDX_BITS-1:0] head_index;
    logic [CW-1:0]       count;
    logic                push_acc;
    logic                res_acc;
    logic                mispredict_c;
    logic [XLEN-1:0]     redirect_c;

    // Handshakes: a push transfers when push_valid_i && push_ready_o;
    // push_ready_o depends only on occupancy (no same-cycle bypass of a
    // resolve). res_valid_i has no ready: it is taken whenever the queue
    // holds at least one entry and silently ignored when empty.
    assign push_ready_o = (count != CW'(DEPTH));
    assign count_o      = count;
    assign push_acc     = push_valid_i && push_ready_o;
    assign res_acc      = res_valid_i && (count != '0);

    assign push_entry = {push_pc_i, push_taken_i, push_target_i, push_index_i};
    assign {head_pc, head_taken, head_target, head_index} = head_entry;

    // A wrong target only matters when the branch was actually taken.
    assign mispredict_c = res_acc &&
                          ((head_taken != res_taken_i) ||
                           (res_taken_i && (head_target != res_target_i)));
    assign redirect_c   = res_taken_i ? res_target_i : head_pc + XLEN'(PC_STEP);

    pred_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (mispredict_c),
        .push      (push_acc),
        .push_data (push_entry),
        .pop       (res_acc),
        .head_data (head_entry),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
            upd_valid_o   <= 1'b0;
            upd_taken_o   <= 1'b0;
            upd_index_o   <= '0;
            miss_cnt_o    <= '0;
        end else begin
            mispredict_o <= mispredict_c;
            upd_valid_o  <= res_acc;
            if (res_acc) begin
                upd_taken_o <= res_taken_i;
                upd_index_o <= head_index;
            end
            if (mispredict_c) begin
                redirect_pc_o <= redirect_c;
                if (miss_cnt_o != 32'hFFFF_FFFF) begin
                    miss_cnt_o <= miss_cnt_o + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Sits between the fetch-stage branch predictor and the execute stage. Holds an in-order queue of predictions made at fetch (PC, predicted direction, predicted target, PHT index), compares each against its branch outcome when execute resolves it, and produces the mispredict/redirect pulse plus the predictor training strobe (direction and PHT index). On a mispredict it discards all younger queued predictions.

## Interface
Parameters:
- XLEN, 32, PC/target width.
- IDX_BITS, 8, PHT index width (matches predictor history width).
- DEPTH, 4, prediction queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- push_valid_i  in  1  fetch issues a conditional-branch prediction.
- push_ready_o  out  1  queue not full (depends on count only).
- push_pc_i  in  XLEN  branch PC.
- push_taken_i  in  1  predicted direction.
- push_target_i  in  XLEN  predicted target.
- push_index_i  in  IDX_BITS  PHT index used for the prediction.
- res_valid_i  in  1  execute resolves the oldest outstanding branch.
- res_taken_i  in  1  actual direction.
- res_target_i  in  XLEN  actual target.
- mispredict_o  out  1  one-cycle pulse: redirect fetch.
- redirect_pc_o  out  XLEN  correct next PC; valid with mispredict_o.
- upd_valid_o  out  1  one-cycle predictor training strobe.
- upd_taken_o  out  1  actual direction for training.
- upd_index_o  out  IDX_BITS  PHT index to train.
- count_o  out  clog2(DEPTH)+1  entries occupied.
- miss_cnt_o  out  32  saturating mispredict count.

## Operation
- Circular FIFO: wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap), count (0..DEPTH).
- Push accepted when push_valid_i && push_ready_o; entry written at wr_ptr; wr_ptr++.
- Resolve accepted when res_valid_i && count != 0; oldest entry compared; rd_ptr++. res_valid_i with count == 0: ignored, no outputs, no state change.
- Mispredict = (entry.taken != res_taken_i) || (res_taken_i && entry.target != res_target_i).
- redirect_pc = res_taken_i ? res_target_i : entry.pc + 4 (mod 2^XLEN).
- Every accepted resolve: upd_valid_o=1, upd_taken_o=res_taken_i, upd_index_o=entry.index, whether or not mispredicted.
- Mispredict: queue flushed (wr_ptr=rd_ptr=0, count=0) at the same edge; a push accepted in that cycle is discarded; miss_cnt increments, saturating at 0xFFFF_FFFF.
- Push and non-mispredicting resolve in same cycle: both take effect, count unchanged.
- Full: push_ready_o=0 even if a resolve occurs that cycle (no bypass).

## Timing
- All outputs except push_ready_o/count_o registered; resolve in cycle N -> mispredict_o/upd_* high in cycle N+1 only.
- push_ready_o and count_o reflect state at start of cycle; push visible in count_o next cycle.
- Reset: pointers, count, miss_cnt = 0; mispredict_o, upd_valid_o, upd_taken_o = 0; redirect_pc_o, upd_index_o = 0; push_ready_o = 1. Reset mid-operation discards all entries and suppresses any pending pulse in the following cycle.
- Resolve latency: no minimum; an entry pushed at edge N may resolve in cycle N+1.

## Structure
- Shared package: XLEN/IDX_BITS defaults, PC_STEP = 4, queue entry struct {pc, taken, target, index}.
- One sub-module: pred_queue (parameterised FIFO with flush input, push/pop, count); comparison, redirect and counters live in the top.

## Test plan
- Push pc=0x100 taken=1 target=0x200 idx=0x12; resolve taken=1 target=0x200 -> next cycle upd_valid=1 upd_taken=1 upd_index=0x12, mispredict_o=0.
- Push pc=0x100 taken=1; resolve taken=0 -> mispredict_o=1, redirect_pc_o=0x104, miss_cnt_o=1, count_o=0.
- Push taken=1 target=0x200; resolve taken=1 target=0x300 -> mispredict_o=1, redirect_pc_o=0x300, upd_taken_o=1.
- Push 4 entries (DEPTH=4) -> push_ready_o=0; resolve+push same cycle -> push not accepted; resolve 4 correct, push 4 more -> pointers wrap, PHT indices returned in push order.
- 3 queued, oldest mispredicts while push_valid_i=1 -> count_o=0 next cycle, queued entries and new push never produce upd_valid_o.
- Resolve with empty queue -> no pulse; assert rst with 2 entries queued -> count_o=0, push_ready_o=1, no pulses following.
